// File: rtl/battle_pkg.sv
// Shared battle-screen constants: visible bounds, sprite size, switch map and attack FSM encoding.
package battle_pkg;

    localparam int unsigned H_VIS_START = 144;
    localparam int unsigned H_VIS_END   = 783;
    localparam int unsigned V_VIS_START = 31;
    localparam int unsigned V_VIS_END   = 510;

    localparam int unsigned SPR_W = 32;
    localparam int unsigned SPR_H = 48;

    localparam int unsigned POS_W = 10;
    localparam int unsigned EXT_W = POS_W + 1;
    localparam int unsigned SW_W  = 7;

    localparam int unsigned SW_UP       = 0;
    localparam int unsigned SW_DOWN     = 1;
    localparam int unsigned SW_LEFT     = 2;
    localparam int unsigned SW_RIGHT    = 3;
    localparam int unsigned SW_ATTACK   = 4;
    localparam int unsigned SW_BOOST    = 5;
    localparam int unsigned SW_RECENTRE = 6;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LUNGE    = 2'd1,
        ST_RETURN   = 2'd2,
        ST_COOLDOWN = 2'd3
    } atk_state_e;

endpackage

// File: rtl/frame_debouncer.sv
// Synchronises vs and the switches, emits a 1-clk frame tick on vs rise and
// debounces each switch over consecutive frame samples.
module frame_debouncer
    import battle_pkg::*;
#(
    parameter int unsigned DEB_FRAMES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SW_W-1:0] switch_i,
    input  logic            vs_i,
    output logic            tick_o,
    output logic [SW_W-1:0] sw_deb_o
);

    localparam int unsigned DCNT_W = (DEB_FRAMES > 1) ? $clog2(DEB_FRAMES) : 1;

    logic [SW_W-1:0]   sw_s1_q, sw_s2_q;
    logic              vs_s1_q, vs_s2_q, vs_prev_q;
    logic              tick_q;
    logic              tick_c;
    logic [SW_W-1:0]   deb_q, deb_d;
    logic [DCNT_W-1:0] cnt_q [SW_W];
    logic [DCNT_W-1:0] cnt_d [SW_W];

    assign tick_c = vs_s2_q & ~vs_prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q   <= '0;
            sw_s2_q   <= '0;
            vs_s1_q   <= 1'b0;
            vs_s2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
            tick_q    <= 1'b0;
            deb_q     <= '0;
            for (int i = 0; i < int'(SW_W); i++) cnt_q[i] <= '0;
        end else begin
            sw_s1_q   <= switch_i;
            sw_s2_q   <= sw_s1_q;
            vs_s1_q   <= vs_i;
            vs_s2_q   <= vs_s1_q;
            vs_prev_q <= vs_s2_q;
            tick_q    <= tick_c;
            deb_q     <= deb_d;
            for (int i = 0; i < int'(SW_W); i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // A bit flips only after DEB_FRAMES consecutive disagreeing samples.
    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < int'(SW_W); i++) cnt_d[i] = cnt_q[i];
        if (tick_c) begin
            for (int i = 0; i < int'(SW_W); i++) begin
                if (sw_s2_q[i] == deb_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == DCNT_W'(DEB_FRAMES - 1)) begin
                    deb_d[i] = sw_s2_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + DCNT_W'(1);
                end
            end
        end
    end

    assign tick_o   = tick_q;
    assign sw_deb_o = deb_q;

endmodule

// File: rtl/battle_sprite_ctrl.sv
// Battle sprite position, walk animation and attack lunge, updated once per frame tick.
module battle_sprite_ctrl
    import battle_pkg::*;
#(
    parameter int unsigned X_INIT       = 200,
    parameter int unsigned Y_INIT       = 400,
    parameter int unsigned X_MIN        = H_VIS_START,
    parameter int unsigned X_MAX        = H_VIS_END - SPR_W + 1,
    parameter int unsigned Y_MIN        = V_VIS_START,
    parameter int unsigned Y_MAX        = V_VIS_END - SPR_H + 1,
    parameter int unsigned STEP         = 2,
    parameter int unsigned DEB_FRAMES   = 2,
    parameter int unsigned LUNGE_STEP   = 8,
    parameter int unsigned LUNGE_FRAMES = 4,
    parameter int unsigned COOL_FRAMES  = 8,
    parameter int unsigned ANIM_FRAMES  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  switch,
    input  logic             vs,
    output logic [POS_W-1:0] sprite_x,
    output logic [POS_W-1:0] sprite_y,
    output logic             anim_phase,
    output logic             attack_pulse,
    output logic             busy
);

    localparam int unsigned FCNT_MAX = (COOL_FRAMES > LUNGE_FRAMES) ? COOL_FRAMES : LUNGE_FRAMES;
    localparam int unsigned FCNT_W   = $clog2(FCNT_MAX + 1);
    localparam int unsigned ANIM_W   = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic            tick;
    logic [SW_W-1:0] sw_deb;

    frame_debouncer #(.DEB_FRAMES(DEB_FRAMES)) u_frame_debouncer (
        .clk      (clk),
        .rst      (rst),
        .switch_i (switch),
        .vs_i     (vs),
        .tick_o   (tick),
        .sw_deb_o (sw_deb)
    );

    atk_state_e        state_q, state_d;
    logic [POS_W-1:0]  x_q, x_d, y_q, y_d, home_q, home_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [ANIM_W-1:0] acnt_q, acnt_d;
    logic              anim_q, anim_d;
    logic              pulse_q, pulse_d;
    logic              busy_q, busy_d;
    logic              atk_prev_q, atk_prev_d;

    // Movement datapath: signed delta, then clamp to the legal box.
    logic signed [EXT_W-1:0] step_s, dx_s, dy_s, nx_s, ny_s;
    logic [POS_W-1:0]        x_mv, y_mv, x_lunge, x_ret;
    logic                    moving;

    always_comb begin
        step_s = sw_deb[SW_BOOST] ? $signed(EXT_W'(2 * STEP)) : $signed(EXT_W'(STEP));
        dx_s   = '0;
        dy_s   = '0;
        if (sw_deb[SW_RIGHT] && !sw_deb[SW_LEFT]) dx_s = step_s;
        if (sw_deb[SW_LEFT] && !sw_deb[SW_RIGHT]) dx_s = -step_s;
        if (sw_deb[SW_DOWN] && !sw_deb[SW_UP])    dy_s = step_s;
        if (sw_deb[SW_UP] && !sw_deb[SW_DOWN])    dy_s = -step_s;
        moving = (dx_s != '0) || (dy_s != '0);
        nx_s   = $signed({1'b0, x_q}) + dx_s;
        ny_s   = $signed({1'b0, y_q}) + dy_s;

        if (nx_s < $signed(EXT_W'(X_MIN)))      x_mv = POS_W'(X_MIN);
        else if (nx_s > $signed(EXT_W'(X_MAX))) x_mv = POS_W'(X_MAX);
        else                                    x_mv = nx_s[POS_W-1:0];

        if (ny_s < $signed(EXT_W'(Y_MIN)))      y_mv = POS_W'(Y_MIN);
        else if (ny_s > $signed(EXT_W'(Y_MAX))) y_mv = POS_W'(Y_MAX);
        else                                    y_mv = ny_s[POS_W-1:0];

        x_lunge = (({1'b0, x_q} + EXT_W'(LUNGE_STEP)) > EXT_W'(X_MAX))
                  ? POS_W'(X_MAX) : x_q + POS_W'(LUNGE_STEP);
        x_ret   = ({1'b0, x_q} < ({1'b0, home_q} + EXT_W'(LUNGE_STEP)))
                  ? home_q : x_q - POS_W'(LUNGE_STEP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            x_q        <= POS_W'(X_INIT);
            y_q        <= POS_W'(Y_INIT);
            home_q     <= POS_W'(X_INIT);
            fcnt_q     <= '0;
            acnt_q     <= '0;
            anim_q     <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
            atk_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            home_q     <= home_d;
            fcnt_q     <= fcnt_d;
            acnt_q     <= acnt_d;
            anim_q     <= anim_d;
            pulse_q    <= pulse_d;
            busy_q     <= busy_d;
            atk_prev_q <= atk_prev_d;
        end
    end

    // Attack FSM and per-tick position/animation update.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        home_d     = home_q;
        fcnt_d     = fcnt_q;
        acnt_d     = acnt_q;
        anim_d     = anim_q;
        pulse_d    = 1'b0;
        atk_prev_d = atk_prev_q;

        if (tick) begin
            atk_prev_d = sw_deb[SW_ATTACK];
            if (sw_deb[SW_RECENTRE]) begin
                state_d = ST_IDLE;
                x_d     = POS_W'(X_INIT);
                y_d     = POS_W'(Y_INIT);
                fcnt_d  = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (sw_deb[SW_ATTACK] && !atk_prev_q) begin
                            state_d = ST_LUNGE;
                            home_d  = x_q;
                            pulse_d = 1'b1;
                            fcnt_d  = FCNT_W'(LUNGE_FRAMES);
                        end else begin
                            x_d = x_mv;
                            y_d = y_mv;
                            if (moving) begin
                                if (acnt_q == ANIM_W'(ANIM_FRAMES - 1)) begin
                                    acnt_d = '0;
                                    anim_d = ~anim_q;
                                end else begin
                                    acnt_d = acnt_q + ANIM_W'(1);
                                end
                            end
                        end
                    end
                    ST_LUNGE: begin
                        x_d    = x_lunge;
                        fcnt_d = fcnt_q - FCNT_W'(1);
                        if (fcnt_d == '0) begin
                            state_d = ST_RETURN;
                            fcnt_d  = FCNT_W'(LUNGE_FRAMES);
                        end
                    end
                    ST_RETURN: begin
                        x_d    = x_ret;
                        fcnt_d = fcnt_q - FCNT_W'(1);
                        if (fcnt_d == '0) begin
                            x_d     = home_q;
                            state_d = ST_COOLDOWN;
                            fcnt_d  = FCNT_W'(COOL_FRAMES);
                        end
                    end
                    ST_COOLDOWN: begin
                        fcnt_d = fcnt_q - FCNT_W'(1);
                        if (fcnt_d == '0) state_d = ST_IDLE;
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign sprite_x     = x_q;
    assign sprite_y     = y_q;
    assign anim_phase   = anim_q;
    assign attack_pulse = pulse_q;
    assign busy         = busy_q;

endmodule

// File: doc/battle_sprite_ctrl.md
Name: battle_sprite_ctrl

Overview:
- Produces the battle sprite's top-left position, animation phase and attack status consumed by the battle screen renderer.
- Inputs are the 7 board switches and the renderer's vs output.
- Position updates once per video frame, at the vs rising edge, so the sprite never tears mid-frame.
- Contains a switch synchroniser/debouncer, a frame-tick detector, a movement datapath with clamping, and an attack state machine.

Parameters:
- X_INIT, 200, reset/recentre x (renderer hcount space)
- Y_INIT, 400, reset/recentre y (renderer vcount space)
- X_MIN, 144, leftmost legal x
- X_MAX, 752, rightmost legal x (783 - 32 + 1)
- Y_MIN, 31, topmost legal y
- Y_MAX, 463, bottommost legal y (510 - 48 + 1)
- STEP, 2, pixels moved per frame per axis
- DEB_FRAMES, 2, consecutive frame samples required to accept a switch change
- LUNGE_STEP, 8, pixels per frame during attack lunge
- LUNGE_FRAMES, 4, frames spent in LUNGE and in RETURN each
- COOL_FRAMES, 8, frames spent in COOLDOWN
- ANIM_FRAMES, 8, frames per animation toggle while moving

Ports:
- clk  in  1  system clock (same 4x pixel clock the renderer divides)
- rst  in  1  reset, asynchronous, active-high
- switch  in  7  raw switches: [0] up, [1] down, [2] left, [3] right, [4] attack, [5] boost (2x STEP), [6] recentre
- vs  in  1  renderer vertical sync, low during vcount 0..1, pixel-clock domain
- sprite_x  out  10  sprite left column
- sprite_y  out  10  sprite top row
- anim_phase  out  1  walk-cycle frame select
- attack_pulse  out  1  one-clk strobe on attack start
- busy  out  1  high whenever the attack FSM is not IDLE

Behaviour:
Reset:
- Applies asynchronously.
- Outputs: sprite_x=X_INIT, sprite_y=Y_INIT, anim_phase=0, attack_pulse=0, busy=0.
- Internal state: FSM=IDLE, all counters 0, debounced switches 0, synchronisers 0.
- Reset mid-attack aborts the attack immediately.

Frame tick:
- vs passes through a 2-flop synchroniser, then a rising-edge detector; the result is a 1-clk tick.
- All state and output updates occur in the clk cycle after the tick; outputs are registered.
- Latency from vs rise to updated position is at most 4 clk, well before visible row 31.

Debounce:
- switch passes through a 2-flop synchroniser.
- Synchronised switches are sampled on each tick.
- A debounced bit changes only after DEB_FRAMES consecutive ticks sample the new value.
- One counter per bit; the counter clears whenever the sample equals the debounced value.

Movement, evaluated in IDLE on each tick:
- step = STEP, or 2*STEP when boost is set.
- dx = +step for right only, -step for left only, 0 for both or neither. dy is the same with down = +, up = -.
- Compute in 11-bit signed arithmetic, then clamp to [X_MIN, X_MAX] and [Y_MIN, Y_MAX]. No wrap-around.
- Recentre set: position becomes X_INIT/Y_INIT; movement and attack are ignored that tick.
- anim_phase:
  - Frame counter increments on ticks where dx or dy is nonzero.
  - At ANIM_FRAMES-1 the counter wraps to 0 and anim_phase toggles.
  - When not moving, the counter and anim_phase hold.

Attack FSM:
- States: IDLE, LUNGE, RETURN, COOLDOWN.
- IDLE -> LUNGE on a tick where the debounced attack rises (0->1) and recentre is clear.
  - Latches x_home = sprite_x.
  - Asserts attack_pulse for 1 clk.
  - Loads frame counter = LUNGE_FRAMES.
- LUNGE:
  - Each tick: x = min(x + LUNGE_STEP, X_MAX), counter decrements.
  - At 0: go to RETURN and reload the counter.
- RETURN:
  - Each tick: x = max(x - LUNGE_STEP, x_home).
  - At 0: force x = x_home, go to COOLDOWN, load COOL_FRAMES.
- COOLDOWN:
  - Counts ticks.
  - At 0: go to IDLE.
- Attack level held through the attack does not retrigger; only a fresh rise does.
- Outside IDLE: direction and boost are ignored, y is frozen, anim_phase holds.
- Recentre outside IDLE: on the next tick, abort to IDLE and set the position to X_INIT/Y_INIT.
- busy is high in LUNGE, RETURN and COOLDOWN.

Decomposition:
- Shared package battle_pkg holds:
  - screen bounds (H_VIS_START 144, H_VIS_END 783, V_VIS_START 31, V_VIS_END 510)
  - sprite size (32x48)
  - switch bit indices
  - FSM state encoding
- The renderer imports the same bounds from battle_pkg.
- One sub-module: frame_debouncer (synchroniser, per-bit debounce counters, vs tick generator), which outputs the tick and the debounced switch vector.

Test Plan:
- Reset then 3 frames with no switches -> sprite_x=200, sprite_y=400, busy=0, anim_phase=0.
- Right held (after DEB_FRAMES=2) for 10 ticks -> sprite_x=220; with boost also set -> +4 per tick; both left and right set -> x unchanged.
- Up held from y=35 -> y=33, 31, then stays 31. Right held from x=750 -> 752, then stays 752.
- Attack rise at x=200 -> attack_pulse one clk, busy=1, x=208/216/224/232, then back to 200 over 4 ticks, busy falls after 8 further ticks; attack held throughout -> no second attack.
- Recentre asserted during LUNGE at x=216 -> next tick x=200, y=400, busy=0.
- Switch glitch lasting 1 frame -> no movement. rst asserted mid-RETURN (async, between clk edges) -> outputs at reset values immediately.
